// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state type and screen constants for the frame draw scheduler
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW_GO,
    DRAW,
    HOLD
  } fds_state_t;

  localparam int   SCREEN_W    = 640;
  localparam int   SCREEN_H    = 480;
  localparam logic COLOR_CLEAR = 1'b0;
  localparam logic COLOR_DRAW  = 1'b1;

endpackage

// File: rtl/fb_write_mux.sv
// rtl/fb_write_mux.sv - registered clear/draw selection onto the framebuffer write port
import fb_pkg::*;

module fb_write_mux #(
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  fds_state_t         state,
  input  logic               clr_done,
  input  logic [COORD_W-1:0] clr_x,
  input  logic [COORD_W-1:0] clr_y,
  input  logic               drw_valid,
  input  logic [COORD_W-1:0] drw_x,
  input  logic [COORD_W-1:0] drw_y,
  output logic               fb_we,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic               fb_color
);

  logic               sel_we;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic               sel_color;

  // Pick the source that owns the port; the clr_done cycle carries no pixel.
  always_comb begin
    sel_we    = 1'b0;
    sel_x     = clr_x;
    sel_y     = clr_y;
    sel_color = COLOR_CLEAR;
    case (state)
      CLEAR: begin
        sel_we    = ~clr_done;
        sel_x     = clr_x;
        sel_y     = clr_y;
        sel_color = COLOR_CLEAR;
      end
      DRAW: begin
        sel_we    = drw_valid;
        sel_x     = drw_x;
        sel_y     = drw_y;
        sel_color = COLOR_DRAW;
      end
      default: begin
        sel_we = 1'b0;
      end
    endcase
  end

  // One-cycle registered write stage; address and colour hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we    <= 1'b0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= 1'b0;
    end else begin
      fb_we <= sel_we;
      if (sel_we) begin
        fb_x     <= sel_x;
        fb_y     <= sel_y;
        fb_color <= sel_color;
      end
    end
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - clear, draw and hold sequencing for one animation frame
import fb_pkg::*;

module frame_draw_scheduler #(
  parameter int HOLD_CYCLES = 1000,
  parameter int COORD_W     = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               loop,
  output logic               clr_enable,
  input  logic               clr_done,
  input  logic [COORD_W-1:0] clr_x,
  input  logic [COORD_W-1:0] clr_y,
  output logic               drw_start,
  input  logic               drw_valid,
  input  logic [COORD_W-1:0] drw_x,
  input  logic [COORD_W-1:0] drw_y,
  input  logic               drw_done,
  output logic               fb_we,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic               fb_color,
  output logic               busy,
  output logic [7:0]         frame_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  fds_state_t        state;
  fds_state_t        state_n;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_last;

  assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  // Control outputs decode straight from the state register, so reset clears them at once.
  assign clr_enable = (state == CLEAR);
  assign drw_start  = (state == DRAW_GO);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; each state only looks at the inputs it owns.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CLEAR;
      CLEAR:   if (clr_done) state_n = DRAW_GO;
      DRAW_GO: state_n = DRAW;
      DRAW:    if (drw_done) state_n = HOLD;
      HOLD:    if (hold_last) state_n = loop ? CLEAR : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Hold counter runs only inside HOLD and is zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state == HOLD && !hold_last) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  // Completed-frame counter bumps on the DRAW to HOLD transition and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= 8'd0;
    end else if (state_n == HOLD && state != HOLD) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  fb_write_mux #(
    .COORD_W (COORD_W)
  ) u_write_mux (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .clr_done  (clr_done),
    .clr_x     (clr_x),
    .clr_y     (clr_y),
    .drw_valid (drw_valid),
    .drw_x     (drw_x),
    .drw_y     (drw_y),
    .fb_we     (fb_we),
    .fb_x      (fb_x),
    .fb_y      (fb_y),
    .fb_color  (fb_color)
  );

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - directed self-checking bench for frame_draw_scheduler
module tb_frame_draw_scheduler;

  localparam int CW   = 11;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          loop;
  logic          clr_enable;
  logic          clr_done;
  logic [CW-1:0] clr_x;
  logic [CW-1:0] clr_y;
  logic          drw_start;
  logic          drw_valid;
  logic [CW-1:0] drw_x;
  logic [CW-1:0] drw_y;
  logic          drw_done;
  logic          fb_we;
  logic [CW-1:0] fb_x;
  logic [CW-1:0] fb_y;
  logic          fb_color;
  logic          busy;
  logic [7:0]    frame_count;

  int checks   = 0;
  int failures = 0;

  frame_draw_scheduler #(
    .HOLD_CYCLES (HOLD),
    .COORD_W     (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .loop        (loop),
    .clr_enable  (clr_enable),
    .clr_done    (clr_done),
    .clr_x       (clr_x),
    .clr_y       (clr_y),
    .drw_start   (drw_start),
    .drw_valid   (drw_valid),
    .drw_x       (drw_x),
    .drw_y       (drw_y),
    .drw_done    (drw_done),
    .fb_we       (fb_we),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_color    (fb_color),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Stand-in clear engine: raster sweep of clr_w x clr_h while enabled, then clr_done.
  int            clr_w = 16;
  int            clr_h = 8;
  logic [CW-1:0] cx    = '0;
  logic [CW-1:0] cy    = '0;
  logic          cdone = 1'b0;

  assign clr_x    = cx;
  assign clr_y    = cy;
  assign clr_done = cdone;

  always @(posedge clk) begin
    if (clr_enable !== 1'b1) begin
      cx    <= '0;
      cy    <= '0;
      cdone <= 1'b0;
    end else if (!cdone) begin
      if (cx == CW'(clr_w - 1)) begin
        cx <= '0;
        if (cy == CW'(clr_h - 1)) cdone <= 1'b1;
        else cy <= cy + CW'(1);
      end else begin
        cx <= cx + CW'(1);
      end
    end
  end

  // Write monitor: counts writes by colour and tracks clear-pass coverage.
  int wr_cnt, wr_zero, wr_one, dup_cnt, cov_cnt, mon_idx;
  bit cov_map [0:127];

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      wr_cnt++;
      if (fb_color === 1'b1) wr_one++;
      else wr_zero++;
      if (fb_color === 1'b0 && int'(fb_x) < clr_w && int'(fb_y) < clr_h) begin
        mon_idx = int'(fb_y) * clr_w + int'(fb_x);
        if (cov_map[mon_idx]) dup_cnt++;
        else begin
          cov_map[mon_idx] = 1'b1;
          cov_cnt++;
        end
      end
    end
  end

  task automatic mon_clear();
    wr_cnt = 0; wr_zero = 0; wr_one = 0; dup_cnt = 0; cov_cnt = 0;
    for (int i = 0; i < 128; i++) cov_map[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int to;
  int bad_to;
  bit idle_seen;

  initial begin
    reset = 1'b1; start = 1'b0; loop = 1'b0;
    drw_valid = 1'b0; drw_done = 1'b0; drw_x = '0; drw_y = '0;
    mon_clear();
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_clr_enable", int'(clr_enable), 0);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_drw_start", int'(drw_start), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    reset = 1'b0;
    tick();
    chk("idle_without_start", int'(busy), 0);

    // Clear pass over a 16x8 region.
    mon_clear();
    start = 1'b1; tick(); start = 1'b0;
    chk("clr_enable_rise", int'(clr_enable), 1);
    chk("clear_busy", int'(busy), 1);
    chk("clear_first_no_write", int'(fb_we), 0);
    to = 0;
    while (clr_done !== 1'b1 && to < 1000) begin tick(); to++; end
    chk("clr_done_timeout", int'(to < 1000), 1);
    tick();
    chk("clr_done_cycle_no_write", int'(fb_we), 0);
    chk("clr_enable_drop", int'(clr_enable), 0);
    chk("drw_start_high", int'(drw_start), 1);
    chk("clear_write_count", wr_cnt, 128);
    chk("clear_color_zero", wr_zero, 128);
    chk("clear_coverage", cov_cnt, 128);
    chk("clear_duplicates", dup_cnt, 0);
    chk("clear_last_x_held", int'(fb_x), 15);
    chk("clear_last_y_held", int'(fb_y), 7);

    // Draw pass: five pixels, a gap, then a pixel with drw_done.
    tick();
    chk("drw_start_single", int'(drw_start), 0);
    mon_clear();
    for (int i = 0; i < 5; i++) begin
      drw_valid = 1'b1; drw_x = CW'(i); drw_y = CW'(2 * i + 1); start = (i == 2);
      tick();
      chk("draw_we", int'(fb_we), 1);
      chk("draw_x", int'(fb_x), i);
      chk("draw_y", int'(fb_y), 2 * i + 1);
      chk("draw_color", int'(fb_color), 1);
      chk("draw_start_ignored", int'(clr_enable), 0);
    end
    drw_valid = 1'b0; start = 1'b0; drw_x = CW'(77);
    tick();
    chk("draw_gap_we", int'(fb_we), 0);
    chk("draw_gap_x_held", int'(fb_x), 4);
    drw_valid = 1'b1; drw_done = 1'b1; drw_x = CW'(10); drw_y = CW'(20);
    tick();
    chk("draw_last_we", int'(fb_we), 1);
    chk("draw_last_x", int'(fb_x), 10);
    chk("draw_last_y", int'(fb_y), 20);
    chk("hold_entry_frame_count", int'(frame_count), 1);

    // Hold with loop=0, stray drawer activity must be ignored.
    drw_done = 1'b0; drw_valid = 1'b1; drw_x = CW'(99);
    to = 0;
    while (busy === 1'b1 && to < 20) begin tick(); to++; end
    chk("hold_length", to, HOLD);
    chk("draw_total_writes", wr_cnt, 6);
    chk("draw_color_one", wr_one, 6);
    chk("idle_frame_count", int'(frame_count), 1);
    chk("idle_clr_enable", int'(clr_enable), 0);
    drw_valid = 1'b0;

    // Looping frame over a 4x2 region, drawer noise during CLEAR.
    clr_w = 4; clr_h = 2; loop = 1'b1;
    mon_clear();
    start = 1'b1; tick(); start = 1'b0;
    drw_valid = 1'b1; drw_done = 1'b1; drw_x = CW'(5); drw_y = CW'(5);
    to = 0;
    while (clr_done !== 1'b1 && to < 100) begin tick(); to++; end
    chk("loop_clr_done_timeout", int'(to < 100), 1);
    drw_valid = 1'b0; drw_done = 1'b0;
    tick();
    chk("loop_clear_writes", wr_cnt, 8);
    chk("loop_clear_no_draw_color", wr_one, 0);
    chk("loop_drw_start", int'(drw_start), 1);
    tick();
    drw_valid = 1'b1; drw_done = 1'b1; drw_x = CW'(3); drw_y = CW'(4);
    tick();
    drw_valid = 1'b0; drw_done = 1'b0;
    chk("loop_frame_count", int'(frame_count), 2);
    chk("loop_draw_x", int'(fb_x), 3);
    idle_seen = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      if (busy !== 1'b1) idle_seen = 1'b1;
    end
    chk("loop_no_idle", int'(idle_seen), 0);
    chk("loop_clr_reassert", int'(clr_enable), 1);

    // Asynchronous reset in the middle of a clear pass.
    tick();
    chk("pre_reset_clear_write", int'(fb_we), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_clr_enable", int'(clr_enable), 0);
    chk("async_rst_fb_we", int'(fb_we), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_frame_count", int'(frame_count), 0);
    loop = 1'b0; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    chk("post_reset_idle", int'(busy), 0);

    // 256 looped frames with a one-pixel clear region.
    clr_w = 1; clr_h = 1; loop = 1'b1; bad_to = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int f = 1; f <= 256; f++) begin
      to = 0;
      while (drw_start !== 1'b1 && to < 50) begin tick(); to++; end
      if (to >= 50) bad_to++;
      tick();
      drw_done = 1'b1;
      tick();
      drw_done = 1'b0;
      if (f == 255) chk("wrap_at_255", int'(frame_count), 255);
    end
    chk("wrap_timeouts", bad_to, 0);
    chk("wrap_to_zero", int'(frame_count), 0);
    loop = 1'b0;
    to = 0;
    while (busy === 1'b1 && to < 50) begin tick(); to++; end
    chk("final_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
